con_seq_vm: RTL and testbench
=============================

Name: con_seq_vm

Overview:
- Sequencer for the 3-bit up/down counter datapath.
- Accepts a move command (direction, step count, mode, optional clear) over a valid/ready handshake.
- Drives the counter's step enable, direction select `x` and clear, and watches the counter output to stop or reverse at the range bounds.
- Sits between the control/FSM layer and the counter instance; it is the only agent that drives the counter's inputs.

Parameters:
- W, 3, counter width; width of cnt_q.
- LIM_LO, 0, lower bound of the counting range (W bits).
- LIM_HI, 4, upper bound of the counting range (W bits); LIM_HI > LIM_LO.
- STEPS_W, 4, width of the step-count field.

Ports:
- clk  in  1  system clock, rising edge.
- res_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_dir  in  1  initial direction: 1 = up, 0 = down (same encoding as the counter's x).
- cmd_mode  in  1  0 = single sweep (stop at bound), 1 = bounce (reverse at bound).
- cmd_clr  in  1  clear the counter to LIM_LO before stepping.
- cmd_steps  in  STEPS_W  number of steps to issue; 0 is legal.
- abort  in  1  terminate the active command.
- cnt_q  in  W  current counter value (updates 1 cycle after a step).
- cnt_en  out  1  issue one counter step this cycle.
- cnt_x  out  1  counter direction this cycle.
- cnt_clr  out  1  synchronous clear request to the counter.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- hit  out  1  valid with done: sweep ended early at a bound.
- steps_left  out  STEPS_W  remaining steps.

Behaviour:
- Reset (res_n=0, async): state=IDLE; cmd_ready=1; cnt_en=0, cnt_x=0, cnt_clr=0, busy=0, done=0, hit=0, steps_left=0; latched dir=0, mode=0.
- States: IDLE, CLR, RUN, DONE (encoding in the package).
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch dir, mode, steps_left=cmd_steps.
  - Next state: CLR if cmd_clr, else RUN if cmd_steps!=0, else DONE.
- CLR:
  - cnt_clr=1 for exactly 1 cycle, cnt_en=0.
  - Next state: RUN if steps_left!=0, else DONE.
- RUN, per cycle:
  - eff_dir = (mode & dir & cnt_q==LIM_HI) ? 0 : (mode & ~dir & cnt_q==LIM_LO) ? 1 : dir.
  - cnt_x = eff_dir; dir <= eff_dir.
  - Single mode with (dir & cnt_q==LIM_HI) or (~dir & cnt_q==LIM_LO): no step (cnt_en=0); go to DONE with hit=1.
  - Otherwise cnt_en=1 and steps_left decrements; on the step where steps_left==1, go to DONE.
  - abort=1 has priority over everything: cnt_en=0 that cycle, go to DONE, hit=0, steps_left is held.
  - cnt_q is sampled once per cycle. Back-to-back steps are legal because the counter reflects step t at cycle t+1.
- DONE:
  - done=1 for 1 cycle; hit is valid alongside it.
  - Next state: IDLE. cmd_ready=0 during DONE.
- Outputs:
  - busy=1 in CLR/RUN/DONE.
  - cmd_ready=1 only in IDLE.
  - cnt_en and cnt_clr are never both 1.
- Handshake: commands are never accepted while busy. cmd_valid may drop at any time without effect.
- abort in IDLE, CLR or DONE is ignored.
- res_n asserted mid-command returns to IDLE immediately with no done pulse. The counter's own reset is separate and not driven here.
- cnt_q outside [LIM_LO, LIM_HI] is treated as in-range; no bound action is taken.

Decomposition:
- Package con_pkg_vm holds:
  - state encoding localparams (IDLE=2'd0, CLR=2'd1, RUN=2'd2, DONE=2'd3);
  - direction constants DIR_UP=1'b1, DIR_DN=1'b0;
  - mode constants MODE_SWEEP=1'b0, MODE_BOUNCE=1'b1.
- Natural sub-module: con_bound_vm, combinational. Inputs cnt_q, dir, mode. Outputs eff_dir and stop_at_bound.
- The FSM and step counter live in con_seq_vm.

Test Plan:
- Reset mid-RUN (steps=5, after 2 steps) -> outputs return to reset values the same cycle; no done; next command is accepted normally.
- Single up sweep, cnt_q=1, steps=2, mode=0, clr=0 -> cnt_en=1,x=1 for 2 cycles; done on cycle 3; hit=0; cnt_q ends at 3.
- Single up sweep hits the bound: cnt_q=3, steps=5, mode=0 -> one step (cnt_q→4); next cycle no step; done with hit=1; steps_left=4.
- Bounce with clear: clr=1, dir=0, steps=6, mode=1 -> cnt_clr 1 cycle (cnt_q=0); x sequence 1,1,1,1,0,0; cnt_q 0→1→2→3→4→3→2; done with hit=0.
- Abort on 3rd RUN cycle, steps=8 -> no cnt_en on the abort cycle; done the next cycle; steps_left=6; cmd_ready=1 the cycle after.
- Zero steps and a busy command: steps=0 -> done 1 cycle after acceptance, no cnt_en. A cmd_valid held during busy is accepted only once cmd_ready returns high.

Source files
------------

// File: rtl/con_pkg_vm.sv
// Shared constants for the counter sequencer: FSM state encoding,
// direction and mode encodings.
package con_pkg_vm;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CLR  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Direction encoding, identical to the counter's x input
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Command mode encoding
    localparam logic MODE_SWEEP  = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;

endpackage : con_pkg_vm

// File: rtl/con_bound_vm.sv
// Range-bound evaluation for the counter sequencer. Looks at the current
// counter value together with the latched direction and mode, and decides
// the direction to use this cycle and whether a single sweep must stop.
// Values outside [LIM_LO, LIM_HI] match neither bound and pass through.
module con_bound_vm
    import con_pkg_vm::*;
#(
    parameter int unsigned W      = 3,
    parameter int unsigned LIM_LO = 0,
    parameter int unsigned LIM_HI = 4
) (
    input  logic [W-1:0] cnt_q,
    input  logic         dir,
    input  logic         mode,
    output logic         eff_dir,
    output logic         stop_at_bound
);

    logic at_hi_s;
    logic at_lo_s;
    logic up_at_hi_s;
    logic dn_at_lo_s;

    // Bound detection and direction/stop decision for this cycle
    always_comb begin
        at_hi_s       = (cnt_q == W'(LIM_HI));
        at_lo_s       = (cnt_q == W'(LIM_LO));
        up_at_hi_s    = (dir == DIR_UP) && at_hi_s;
        dn_at_lo_s    = (dir == DIR_DN) && at_lo_s;
        eff_dir       = dir;
        stop_at_bound = 1'b0;
        if (mode == MODE_BOUNCE) begin
            // Bounce: reverse at the bound, never stop early
            if (up_at_hi_s) begin
                eff_dir = DIR_DN;
            end else if (dn_at_lo_s) begin
                eff_dir = DIR_UP;
            end else begin
                eff_dir = dir;
            end
        end else begin
            // Sweep: keep direction, request a stop at the bound
            stop_at_bound = up_at_hi_s || dn_at_lo_s;
        end
    end

endmodule : con_bound_vm

// File: rtl/con_seq_vm.sv
// Sequencer for the up/down counter datapath. Accepts a move command over
// a valid/ready handshake, optionally clears the counter, then issues one
// step per cycle while watching the counter value to stop (sweep) or
// reverse (bounce) at the range bounds. It is the only driver of the
// counter's step, direction and clear inputs.
module con_seq_vm
    import con_pkg_vm::*;
#(
    parameter int unsigned W       = 3,
    parameter int unsigned LIM_LO  = 0,
    parameter int unsigned LIM_HI  = 4,
    parameter int unsigned STEPS_W = 4
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic               cmd_mode,
    input  logic               cmd_clr,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic               abort,
    input  logic [W-1:0]       cnt_q,
    output logic               cnt_en,
    output logic               cnt_x,
    output logic               cnt_clr,
    output logic               busy,
    output logic               done,
    output logic               hit,
    output logic [STEPS_W-1:0] steps_left
);

    logic [1:0]         state_q, state_d;
    logic               dir_q, dir_d;
    logic               mode_q, mode_d;
    logic               hit_q, hit_d;
    logic [STEPS_W-1:0] steps_q, steps_d;
    logic               eff_dir_s;
    logic               stop_s;

    con_bound_vm #(
        .W      (W),
        .LIM_LO (LIM_LO),
        .LIM_HI (LIM_HI)
    ) u_bound (
        .cnt_q         (cnt_q),
        .dir           (dir_q),
        .mode          (mode_q),
        .eff_dir       (eff_dir_s),
        .stop_at_bound (stop_s)
    );

    // State, latched command fields and step counter registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            hit_q   <= 1'b0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            hit_q   <= hit_d;
            steps_q <= steps_d;
        end
    end

    // Next-state and next-register computation
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        hit_d   = hit_q;
        steps_d = steps_q;
        case (state_q)
            IDLE: begin
                // cmd_ready is high in IDLE, so valid alone means accept
                if (cmd_valid) begin
                    dir_d   = cmd_dir;
                    mode_d  = cmd_mode;
                    steps_d = cmd_steps;
                    hit_d   = 1'b0;
                    if (cmd_clr) begin
                        state_d = CLR;
                    end else if (cmd_steps != '0) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CLR: begin
                if (steps_q != '0) begin
                    state_d = RUN;
                end else begin
                    state_d = DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort wins: no step, remaining count and direction held
                    hit_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    dir_d = eff_dir_s;
                    if (stop_s) begin
                        hit_d   = 1'b1;
                        state_d = DONE;
                    end else if (steps_q == '0) begin
                        hit_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        steps_d = steps_q - STEPS_W'(1);
                        if (steps_q == STEPS_W'(1)) begin
                            hit_d   = 1'b0;
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from state, with the step enable qualified by this
    // cycle's bound check and abort
    always_comb begin
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        hit        = 1'b0;
        cnt_en     = 1'b0;
        cnt_x      = 1'b0;
        cnt_clr    = 1'b0;
        steps_left = steps_q;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            CLR: begin
                cnt_clr = 1'b1;
            end
            RUN: begin
                cnt_x  = eff_dir_s;
                cnt_en = !abort && !stop_s && (steps_q != '0);
            end
            DONE: begin
                done = 1'b1;
                hit  = hit_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule : con_seq_vm

// File: tb/tb_con_seq_vm.sv
// Self-checking bench for con_seq_vm. A behavioural 3-bit up/down counter
// closes the loop on cnt_q. Each scenario pushes its expected per-cycle
// output records into a scoreboard queue and pops them as the DUT runs.
module tb_con_seq_vm;

    logic       clk;
    logic       res_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic       cmd_mode;
    logic       cmd_clr;
    logic [3:0] cmd_steps;
    logic       abort;
    logic [2:0] cnt_m;
    logic       cnt_en;
    logic       cnt_x;
    logic       cnt_clr;
    logic       busy;
    logic       done;
    logic       hit;
    logic [3:0] steps_left;

    logic       ld;
    logic [2:0] ld_val;

    int n_cmp;
    int n_fail;

    typedef struct packed {
        logic       en;
        logic       x;
        logic       clr;
        logic       done;
        logic       hit;
        logic       busy;
        logic       ready;
        logic [3:0] steps;
    } rec_t;

    rec_t sb[$];

    con_seq_vm #(
        .W(3), .LIM_LO(0), .LIM_HI(4), .STEPS_W(4)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_mode   (cmd_mode),
        .cmd_clr    (cmd_clr),
        .cmd_steps  (cmd_steps),
        .abort      (abort),
        .cnt_q      (cnt_m),
        .cnt_en     (cnt_en),
        .cnt_x      (cnt_x),
        .cnt_clr    (cnt_clr),
        .busy       (busy),
        .done       (done),
        .hit        (hit),
        .steps_left (steps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural counter: preload, synchronous clear, then up/down step
    always @(posedge clk) begin
        if (ld) begin
            cnt_m <= ld_val;
        end else if (cnt_clr) begin
            cnt_m <= 3'd0;
        end else if (cnt_en) begin
            cnt_m <= cnt_x ? cnt_m + 3'd1 : cnt_m - 3'd1;
        end
    end

    function automatic rec_t mk(logic en, logic x, logic clr, logic dn, logic ht,
                                logic bs, logic rd, logic [3:0] s);
        rec_t r;
        r.en = en; r.x = x; r.clr = clr; r.done = dn; r.hit = ht;
        r.busy = bs; r.ready = rd; r.steps = s;
        return r;
    endfunction

    function automatic rec_t get_obs();
        rec_t r;
        r.en = cnt_en; r.x = cnt_x; r.clr = cnt_clr; r.done = done; r.hit = hit;
        r.busy = busy; r.ready = cmd_ready; r.steps = steps_left;
        return r;
    endfunction

    task automatic set_cmd(input logic v, input logic d, input logic m,
                           input logic c, input logic [3:0] s);
        cmd_valid = v; cmd_dir = d; cmd_mode = m; cmd_clr = c; cmd_steps = s;
    endtask

    task automatic preload(input logic [2:0] v);
        @(negedge clk);
        ld = 1'b1; ld_val = v;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic test_reset();
        rec_t obs, e;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd0));
        @(negedge clk);
        @(negedge clk);
        #1;
        obs = get_obs(); e = sb.pop_front(); n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset: got %b expected %b", obs, e);
        end
        @(negedge clk);
        res_n = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        rec_t obs, e;
        preload(3'd0);
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd0));   // accept steps=5
        sb.push_back(mk(1, 1, 0, 0, 0, 1, 0, 4'd5));
        sb.push_back(mk(1, 1, 0, 0, 0, 1, 0, 4'd4));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd0));   // reset asserted
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd0));   // released, no done
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd0));   // accept steps=0
        sb.push_back(mk(0, 0, 0, 1, 0, 1, 0, 4'd0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) set_cmd(1, 1, 0, 0, 4'd5);
            if (i == 1) set_cmd(0, 1, 0, 0, 4'd5);
            if (i == 3) res_n = 1'b0;
            if (i == 4) res_n = 1'b1;
            if (i == 5) set_cmd(1, 1, 0, 0, 4'd0);
            if (i == 6) set_cmd(0, 1, 0, 0, 4'd0);
            #1;
            obs = get_obs(); e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid_run cyc%0d: got %b expected %b", i, obs, e);
            end
        end
        n_cmp++;
        if (cnt_m !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_mid_run cnt: got %0d expected 2", cnt_m);
        end
    endtask

    task automatic test_single_sweep();
        rec_t obs, e;
        preload(3'd1);
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd0));
        sb.push_back(mk(1, 1, 0, 0, 0, 1, 0, 4'd2));
        sb.push_back(mk(1, 1, 0, 0, 0, 1, 0, 4'd1));
        sb.push_back(mk(0, 0, 0, 1, 0, 1, 0, 4'd0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) set_cmd(1, 1, 0, 0, 4'd2);
            if (i == 1) set_cmd(0, 0, 0, 0, 4'd0);
            #1;
            obs = get_obs(); e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL single_sweep cyc%0d: got %b expected %b", i, obs, e);
            end
        end
        n_cmp++;
        if (cnt_m !== 3'd3) begin
            n_fail++;
            $display("FAIL single_sweep cnt: got %0d expected 3", cnt_m);
        end
    endtask

    task automatic test_hit_bound();
        rec_t obs, e;
        preload(3'd3);
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd0));
        sb.push_back(mk(1, 1, 0, 0, 0, 1, 0, 4'd5));   // 3 -> 4
        sb.push_back(mk(0, 1, 0, 0, 0, 1, 0, 4'd4));   // at bound, no step
        sb.push_back(mk(0, 0, 0, 1, 1, 1, 0, 4'd4));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd4));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) set_cmd(1, 1, 0, 0, 4'd5);
            if (i == 1) set_cmd(0, 0, 0, 0, 4'd0);
            #1;
            obs = get_obs(); e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL hit_bound cyc%0d: got %b expected %b", i, obs, e);
            end
        end
        n_cmp++;
        if (cnt_m !== 3'd4) begin
            n_fail++;
            $display("FAIL hit_bound cnt: got %0d expected 4", cnt_m);
        end
    endtask

    task automatic test_bounce_clear();
        rec_t obs, e;
        logic [5:0] xs;
        xs = 6'b001111;                                 // x per RUN cycle, LSB first
        preload(3'd2);
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd4));
        sb.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4'd6));
        for (int k = 0; k < 6; k++) begin
            sb.push_back(mk(1, xs[k], 0, 0, 0, 1, 0, 4'(6 - k)));
        end
        sb.push_back(mk(0, 0, 0, 1, 0, 1, 0, 4'd0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) set_cmd(1, 0, 1, 1, 4'd6);
            if (i == 1) set_cmd(0, 0, 0, 0, 4'd0);
            #1;
            obs = get_obs(); e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL bounce_clear cyc%0d: got %b expected %b", i, obs, e);
            end
        end
        n_cmp++;
        if (cnt_m !== 3'd2) begin
            n_fail++;
            $display("FAIL bounce_clear cnt: got %0d expected 2", cnt_m);
        end
    endtask

    task automatic test_abort();
        rec_t obs, e;
        preload(3'd0);
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd0));
        sb.push_back(mk(1, 1, 0, 0, 0, 1, 0, 4'd8));
        sb.push_back(mk(1, 1, 0, 0, 0, 1, 0, 4'd7));
        sb.push_back(mk(0, 1, 0, 0, 0, 1, 0, 4'd6));   // abort cycle
        sb.push_back(mk(0, 0, 0, 1, 0, 1, 0, 4'd6));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd6));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) set_cmd(1, 1, 0, 0, 4'd8);
            if (i == 1) set_cmd(0, 0, 0, 0, 4'd0);
            if (i == 3) abort = 1'b1;
            if (i == 4) abort = 1'b0;
            #1;
            obs = get_obs(); e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL abort cyc%0d: got %b expected %b", i, obs, e);
            end
        end
        n_cmp++;
        if (cnt_m !== 3'd2) begin
            n_fail++;
            $display("FAIL abort cnt: got %0d expected 2", cnt_m);
        end
    endtask

    task automatic test_zero_busy();
        rec_t obs, e;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd6));   // accept steps=0
        sb.push_back(mk(0, 0, 0, 1, 0, 1, 0, 4'd0));   // valid held, not taken
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd0));   // accept steps=1
        sb.push_back(mk(1, 1, 0, 0, 0, 1, 0, 4'd1));
        sb.push_back(mk(0, 0, 0, 1, 0, 1, 0, 4'd0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'd0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) set_cmd(1, 1, 0, 0, 4'd0);
            if (i == 2) set_cmd(1, 1, 0, 0, 4'd1);
            if (i == 3) set_cmd(0, 0, 0, 0, 4'd0);
            #1;
            obs = get_obs(); e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL zero_busy cyc%0d: got %b expected %b", i, obs, e);
            end
        end
        n_cmp++;
        if (cnt_m !== 3'd3) begin
            n_fail++;
            $display("FAIL zero_busy cnt: got %0d expected 3", cnt_m);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        res_n  = 1'b0;
        abort  = 1'b0;
        ld     = 1'b1;
        ld_val = 3'd0;
        set_cmd(0, 0, 0, 0, 4'd0);
        test_reset();
        ld = 1'b0;
        test_reset_mid_run();
        test_single_sweep();
        test_hit_bound();
        test_bounce_clear();
        test_abort();
        test_zero_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_con_seq_vm
